// File: rtl/tlc_pkg.sv
// Shared types for the two-road traffic light controller: state encoding,
// lamp triples and the phase timer width.
package tlc_pkg;

  localparam int TIMER_W = 4;

  typedef enum logic [2:0] {
    S_AG  = 3'd0,
    S_AY  = 3'd1,
    S_BG  = 3'd2,
    S_BY  = 3'd3,
    S_AR1 = 3'd4,
    S_AR2 = 3'd5
  } state_e;

  typedef struct packed {
    logic r;
    logic y;
    logic g;
  } lamp_t;

  localparam lamp_t LAMP_RED = 3'b100;
  localparam lamp_t LAMP_YEL = 3'b010;
  localparam lamp_t LAMP_GRN = 3'b001;

  function automatic lamp_t street_a_lamp(state_e s);
    lamp_t l;
    case (s)
      S_AG:    l = LAMP_GRN;
      S_AY:    l = LAMP_YEL;
      default: l = LAMP_RED;
    endcase
    return l;
  endfunction

  function automatic lamp_t street_b_lamp(state_e s);
    lamp_t l;
    case (s)
      S_BG:    l = LAMP_GRN;
      S_BY:    l = LAMP_YEL;
      default: l = LAMP_RED;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Loadable down-counter timing the yellow and all-red phases.
// Saturates at zero; done_o is high whenever the count is zero.
module tlc_phase_timer
  import tlc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  output logic               done_o
);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Moore FSM for a two-street intersection; lamps are registered from the next state.
// Optional all-red clearance between yellow and the opposing green: TLC_ALL_RED_EN.
module traffic_light_ctrl
  import tlc_pkg::*;
#(
  parameter int YELLOW_CYCLES  = 1,
  parameter int ALL_RED_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic ta,
  input  logic tb,
  output logic ra,
  output logic ya,
  output logic ga,
  output logic rb,
  output logic yb,
  output logic gb
);

  if (YELLOW_CYCLES < 1 || YELLOW_CYCLES > 15) begin : g_bad_yellow
    $error("YELLOW_CYCLES must be within 1..15");
  end
  if (ALL_RED_CYCLES < 1 || ALL_RED_CYCLES > 15) begin : g_bad_all_red
    $error("ALL_RED_CYCLES must be within 1..15");
  end

  // Timer is loaded with N-1 on phase entry so the phase lasts exactly N cycles.
  localparam logic [TIMER_W-1:0] YEL_LOAD = TIMER_W'(YELLOW_CYCLES - 1);
`ifdef TLC_ALL_RED_EN
  localparam logic [TIMER_W-1:0] AR_LOAD  = TIMER_W'(ALL_RED_CYCLES - 1);
`endif

  state_e             state_q;
  state_e             state_d;
  lamp_t              lamp_a_q;
  lamp_t              lamp_b_q;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_done;

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = YEL_LOAD;
    case (state_q)
      S_AG: begin
        if (!ta) begin
          state_d  = S_AY;
          tmr_load = 1'b1;
        end
      end
      S_AY: begin
        if (tmr_done) begin
`ifdef TLC_ALL_RED_EN
          state_d  = S_AR1;
          tmr_load = 1'b1;
          tmr_val  = AR_LOAD;
`else
          state_d  = S_BG;
`endif
        end
      end
      S_BG: begin
        if (!tb) begin
          state_d  = S_BY;
          tmr_load = 1'b1;
        end
      end
      S_BY: begin
        if (tmr_done) begin
`ifdef TLC_ALL_RED_EN
          state_d  = S_AR2;
          tmr_load = 1'b1;
          tmr_val  = AR_LOAD;
`else
          state_d  = S_AG;
`endif
        end
      end
`ifdef TLC_ALL_RED_EN
      S_AR1: begin
        if (tmr_done) begin
          state_d = S_BG;
        end
      end
      S_AR2: begin
        if (tmr_done) begin
          state_d = S_AG;
        end
      end
`endif
      default: begin
        state_d = S_AG;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_AG;
      lamp_a_q <= LAMP_GRN;
      lamp_b_q <= LAMP_RED;
    end else begin
      state_q  <= state_d;
      lamp_a_q <= street_a_lamp(state_d);
      lamp_b_q <= street_b_lamp(state_d);
    end
  end

  tlc_phase_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  assign ra = lamp_a_q.r;
  assign ya = lamp_a_q.y;
  assign ga = lamp_a_q.g;
  assign rb = lamp_b_q.r;
  assign yb = lamp_b_q.y;
  assign gb = lamp_b_q.g;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: two instances (yellow of 1 and 3 cycles) share
// stimulus and are compared every cycle against a right-of-way/phase-age model.
module tb_traffic_light_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ta  = 1'b1;
  logic tb  = 1'b0;

  logic ra1, ya1, ga1, rb1, yb1, gb1;
  logic ra3, ya3, ga3, rb3, yb3, gb3;
  logic [5:0] lamps [2];

  int checks = 0;
  int errors = 0;

`ifdef TLC_ALL_RED_EN
  localparam bit ALLRED = 1'b1;
`else
  localparam bit ALLRED = 1'b0;
`endif
  localparam int AR_CYC = 2;

  // Model: owner 0=A 1=B holds right of way; phase 0=green 1=yellow 2=all-red.
  int owner [2];
  int phase [2];
  int age   [2];
  int ycyc  [2];

  always #5 clk = ~clk;

  traffic_light_ctrl #(.YELLOW_CYCLES(1), .ALL_RED_CYCLES(AR_CYC)) u_dut1 (
    .clk(clk), .rst(rst), .ta(ta), .tb(tb),
    .ra(ra1), .ya(ya1), .ga(ga1), .rb(rb1), .yb(yb1), .gb(gb1)
  );

  traffic_light_ctrl #(.YELLOW_CYCLES(3), .ALL_RED_CYCLES(AR_CYC)) u_dut3 (
    .clk(clk), .rst(rst), .ta(ta), .tb(tb),
    .ra(ra3), .ya(ya3), .ga(ga3), .rb(rb3), .yb(yb3), .gb(gb3)
  );

  assign lamps[0] = {ra1, ya1, ga1, rb1, yb1, gb1};
  assign lamps[1] = {ra3, ya3, ga3, rb3, yb3, gb3};

  function automatic logic [5:0] exp_lamps(int k);
    logic [2:0] own;
    logic [2:0] a;
    logic [2:0] b;
    own = (phase[k] == 0) ? 3'b001 : (phase[k] == 1) ? 3'b010 : 3'b100;
    a = (owner[k] == 0) ? own : 3'b100;
    b = (owner[k] == 1) ? own : 3'b100;
    return {a, b};
  endfunction

  function automatic bit inv_ok(logic [5:0] l);
    return ($countones(l[5:3]) == 1) && ($countones(l[2:0]) == 1) && (l[5] || l[2]);
  endfunction

  task automatic model_edge(int k);
    logic sen;
    if (rst) begin
      owner[k] = 0; phase[k] = 0; age[k] = 0;
    end else if (phase[k] == 0) begin
      sen = (owner[k] == 0) ? ta : tb;
      if (!sen) begin
        phase[k] = 1; age[k] = 0;
      end
    end else if (phase[k] == 1) begin
      if (age[k] + 1 == ycyc[k]) begin
        if (ALLRED) begin
          phase[k] = 2; age[k] = 0;
        end else begin
          owner[k] = 1 - owner[k]; phase[k] = 0; age[k] = 0;
        end
      end else begin
        age[k] = age[k] + 1;
      end
    end else begin
      if (age[k] + 1 == AR_CYC) begin
        owner[k] = 1 - owner[k]; phase[k] = 0; age[k] = 0;
      end else begin
        age[k] = age[k] + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ta = 1'b1; tb = 1'b0;
    step();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (lamps[k] !== 6'b001_100) begin
        errors++;
        $display("FAIL reset_state dut%0d got %b want %b", k, lamps[k], 6'b001_100);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (lamps[k] !== 6'b001_100) begin
          errors++;
          $display("FAIL reset_hold cyc%0d dut%0d got %b want %b", i, k, lamps[k], 6'b001_100);
        end
      end
    end
  endtask

  task automatic test_a_to_b();
    ta = 1'b1; tb = 1'b0;
    step();
    step();
    ta = 1'b0; tb = 1'b1;
    step();
    checks++;
    if (lamps[0] !== 6'b010_100) begin
      errors++;
      $display("FAIL a_to_b_yellow got %b want %b", lamps[0], 6'b010_100);
    end
    for (int i = 0; i < 8; i++) begin
      step();
`ifndef TLC_ALL_RED_EN
      if (i == 0) begin
        checks++;
        if (lamps[0] !== 6'b100_001) begin
          errors++;
          $display("FAIL a_to_b_green got %b want %b", lamps[0], 6'b100_001);
        end
      end
`endif
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (lamps[k] !== exp_lamps(k)) begin
          errors++;
          $display("FAIL a_to_b_model cyc%0d dut%0d got %b want %b", i, k, lamps[k], exp_lamps(k));
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (lamps[k] !== 6'b100_001) begin
        errors++;
        $display("FAIL a_to_b_hold dut%0d got %b want %b", k, lamps[k], 6'b100_001);
      end
    end
  endtask

  task automatic test_b_to_a();
    tb = 1'b0; ta = 1'b1;
    step();
    checks++;
    if (lamps[0] !== 6'b100_010) begin
      errors++;
      $display("FAIL b_to_a_yellow got %b want %b", lamps[0], 6'b100_010);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (lamps[k] !== exp_lamps(k)) begin
          errors++;
          $display("FAIL b_to_a_model cyc%0d dut%0d got %b want %b", i, k, lamps[k], exp_lamps(k));
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (lamps[k] !== 6'b001_100) begin
        errors++;
        $display("FAIL b_to_a_green dut%0d got %b want %b", k, lamps[k], 6'b001_100);
      end
    end
  endtask

  task automatic test_sensor_pattern();
    logic [4:0] pa;
    logic [4:0] pb;
    pa = 5'b10110;
    pb = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      ta = pa[i]; tb = pb[i];
      for (int c = 0; c < 2; c++) begin
        step();
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (lamps[k] !== exp_lamps(k)) begin
            errors++;
            $display("FAIL pattern_model bit%0d dut%0d got %b want %b", i, k, lamps[k], exp_lamps(k));
          end
          checks++;
          if (inv_ok(lamps[k]) !== 1'b1) begin
            errors++;
            $display("FAIL pattern_invariant bit%0d dut%0d lamps %b", i, k, lamps[k]);
          end
        end
      end
    end
  endtask

  task automatic test_yellow3();
    int n_ya;
    rst = 1'b1;
    step();
    rst = 1'b0; ta = 1'b1; tb = 1'b0;
    step();
    step();
    ta = 1'b0;
    n_ya = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (lamps[1][4]) n_ya++;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (lamps[k] !== exp_lamps(k)) begin
          errors++;
          $display("FAIL yellow3_model cyc%0d dut%0d got %b want %b", i, k, lamps[k], exp_lamps(k));
        end
      end
      if (i < 3) begin
        ta = 1'($urandom_range(0, 1));
        tb = 1'($urandom_range(0, 1));
      end else begin
        ta = 1'($urandom_range(0, 1));
        tb = 1'b1;
      end
    end
    checks++;
    if (n_ya !== 3) begin
      errors++;
      $display("FAIL yellow3_dwell got %0d cycles want 3", n_ya);
    end
  endtask

  task automatic test_reset_mid_yellow();
    tb = 1'b0; ta = 1'b1;
    step();
    checks++;
    if (lamps[1] !== 6'b100_010) begin
      errors++;
      $display("FAIL midyel_enter got %b want %b", lamps[1], 6'b100_010);
    end
    step();
    checks++;
    if (lamps[1] !== 6'b100_010) begin
      errors++;
      $display("FAIL midyel_cycle2 got %b want %b", lamps[1], 6'b100_010);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (lamps[k] !== 6'b001_100) begin
        errors++;
        $display("FAIL midyel_reset dut%0d got %b want %b", k, lamps[k], 6'b001_100);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      ta  = ($urandom_range(0, 3) != 0);
      tb  = ($urandom_range(0, 2) != 0);
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (lamps[k] !== exp_lamps(k)) begin
          errors++;
          $display("FAIL random_model cyc%0d dut%0d got %b want %b", i, k, lamps[k], exp_lamps(k));
        end
        checks++;
        if (inv_ok(lamps[k]) !== 1'b1) begin
          errors++;
          $display("FAIL random_invariant cyc%0d dut%0d lamps %b", i, k, lamps[k]);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      owner[k] = 0; phase[k] = 0; age[k] = 0;
    end
    ycyc[0] = 1;
    ycyc[1] = 3;
    test_reset();
    test_a_to_b();
    test_b_to_a();
    test_sensor_pattern();
    test_yellow3();
    test_reset_mid_yellow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
